// File: rtl/bira_pkg.sv
// Shared BIRA types and defaults: address/bank widths, the fault entry layout
// and the non-pivot store state encoding.
package bira_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_BNK_W  = 2;

  // Bank code 0 marks "no entry / invalid"
  localparam logic [1:0] BNK_NONE = 2'b00;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] row;
    logic [DEF_ADDR_W-1:0] col;
    logic [DEF_BNK_W-1:0]  bnk;
  } npf_entry_t;

  typedef enum logic {
    COLLECT = 1'b0,
    SCAN    = 1'b1
  } npf_state_e;

endpackage

// File: rtl/npf_entry_match.sv
// Combinational equality compare of an incoming fault report against one
// stored entry; only entries inside the valid range can match.
module npf_entry_match #(
  parameter int unsigned ADDR_W = bira_pkg::DEF_ADDR_W,
  parameter int unsigned BNK_W  = bira_pkg::DEF_BNK_W
) (
  input  logic [ADDR_W-1:0] row,
  input  logic [ADDR_W-1:0] col,
  input  logic [BNK_W-1:0]  bnk,
  input  logic [ADDR_W-1:0] ent_row,
  input  logic [ADDR_W-1:0] ent_col,
  input  logic [BNK_W-1:0]  ent_bnk,
  input  logic              ent_valid,
  output logic              match_c
);

  assign match_c = ent_valid && (row == ent_row) && (col == ent_col) && (bnk == ent_bnk);

endmodule

// File: rtl/npf_store.sv
// Non-pivot fault store: captures BIST fault reports, optionally drops
// duplicates (BIRA_NPF_DEDUP_EN), and streams entries to the comparators.
module npf_store
  import bira_pkg::*;
#(
  parameter int unsigned NPF_DEPTH = 8,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BNK_W     = DEF_BNK_W,
  localparam int unsigned CNT_W    = $clog2(NPF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flt_valid,
  input  logic [ADDR_W-1:0] flt_row,
  input  logic [ADDR_W-1:0] flt_col,
  input  logic [BNK_W-1:0]  flt_bnk,
  output logic              flt_ready,
  input  logic              clr,
  input  logic              scan_start,
  input  logic              scan_col,
  output logic [ADDR_W-1:0] NPry_addr,
  output logic [BNK_W-1:0]  NPry_bnk,
  output logic              np_valid,
  output logic              np_last,
  output logic              scan_done,
  output logic [CNT_W-1:0]  npf_count,
  output logic              overflow
);

  localparam int unsigned IDX_W = $clog2(NPF_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [BNK_W-1:0]  bnk;
  } entry_t;

  entry_t           ent [NPF_DEPTH];
  npf_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic             col_sel;
  logic             dup_c;
  logic             take_c;
  logic             full_c;

  function automatic logic [ADDR_W-1:0] pick(input entry_t e, input logic sel);
    return sel ? e.col : e.row;
  endfunction

`ifdef BIRA_NPF_DEDUP_EN
  logic [NPF_DEPTH-1:0] hit_c;

  for (genvar g = 0; g < NPF_DEPTH; g++) begin : g_match
    npf_entry_match #(
      .ADDR_W(ADDR_W),
      .BNK_W (BNK_W)
    ) u_match (
      .row      (flt_row),
      .col      (flt_col),
      .bnk      (flt_bnk),
      .ent_row  (ent[g].row),
      .ent_col  (ent[g].col),
      .ent_bnk  (ent[g].bnk),
      .ent_valid(CNT_W'(g) < npf_count),
      .match_c  (hit_c[g])
    );
  end

  assign dup_c = |hit_c;
`else
  assign dup_c = 1'b0;
`endif

  assign take_c = flt_valid && (flt_bnk != BNK_W'(BNK_NONE)) && !dup_c;
  assign full_c = (npf_count == CNT_W'(NPF_DEPTH));

  // Entry array is intentionally not reset; npf_count bounds the valid range.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      npf_count <= '0;
      overflow  <= 1'b0;
      flt_ready <= 1'b1;
      NPry_addr <= '0;
      NPry_bnk  <= '0;
      np_valid  <= 1'b0;
      np_last   <= 1'b0;
      scan_done <= 1'b0;
      idx       <= '0;
      last_idx  <= '0;
      col_sel   <= 1'b0;
    end else begin
      np_valid  <= 1'b0;
      np_last   <= 1'b0;
      NPry_addr <= '0;
      NPry_bnk  <= '0;
      scan_done <= 1'b0;
      case (state)
        COLLECT: begin
          if (clr) begin
            npf_count <= '0;
            overflow  <= 1'b0;
          end else begin
            if (take_c) begin
              if (full_c) begin
                overflow <= 1'b1;
              end else begin
                ent[IDX_W'(npf_count)] <= '{row: flt_row, col: flt_col, bnk: flt_bnk};
                npf_count              <= npf_count + 1'b1;
              end
            end
            // Entry 0 is launched on the start edge so it appears one cycle later
            if (scan_start) begin
              if (npf_count == '0) begin
                scan_done <= 1'b1;
              end else begin
                state     <= SCAN;
                flt_ready <= 1'b0;
                col_sel   <= scan_col;
                np_valid  <= 1'b1;
                NPry_addr <= pick(ent[0], scan_col);
                NPry_bnk  <= ent[0].bnk;
                np_last   <= (npf_count == CNT_W'(1));
                idx       <= IDX_W'(1);
                last_idx  <= IDX_W'(npf_count - 1'b1);
              end
            end
          end
        end
        SCAN: begin
          if (np_last) begin
            state     <= COLLECT;
            flt_ready <= 1'b1;
            scan_done <= 1'b1;
            idx       <= '0;
          end else begin
            np_valid  <= 1'b1;
            NPry_addr <= pick(ent[idx], col_sel);
            NPry_bnk  <= ent[idx].bnk;
            np_last   <= (idx == last_idx);
            idx       <= idx + 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
